// File: rtl/row_cmd_emitter_pkg.sv
// Shared widths, command encodings and FSM state type for the row command emitter.
package row_cmd_emitter_pkg;

  localparam int BG_W   = 2;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 16;
  localparam int COL_W  = 10;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_PRE = 3'd1,
    CMD_ACT = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_CAS
  } state_t;

endpackage

// File: rtl/row_cmd_emitter_timer.sv
// Down-counting gap timer shared by the tRP and tRCD waits; done while the count is zero.
module cmd_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/row_cmd_emitter.sv
// Emits PRE/ACT/RD/WR for one request at a time based on the bank tracker's answer,
// enforcing tRP/tRCD gaps and counting row hits, misses and conflicts.
module row_cmd_emitter
  import row_cmd_emitter_pkg::*;
#(
  parameter int T_RP   = 3,
  parameter int T_RCD  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_write,
  input  logic [BG_W-1:0]   req_bank_group,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_type,
  output logic [BG_W-1:0]   cmd_bank_group,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              trk_clear,
  output logic [BG_W-1:0]   trk_query_bank_group,
  output logic [BANK_W-1:0] trk_query_bank,
  input  logic              trk_is_row_open,
  input  logic [ROW_W-1:0]  trk_open_row,
  output logic              trk_upd_activate,
  output logic              trk_upd_precharge,
  output logic [BG_W-1:0]   trk_upd_bank_group,
  output logic [BANK_W-1:0] trk_upd_bank,
  output logic [ROW_W-1:0]  trk_upd_row,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses,
  output logic [STAT_W-1:0] stat_conflicts
);

  // The timer is loaded with T-2: one cycle is the handshake itself, one is the exit transition.
  localparam int WAIT_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  // Handshakes: req accepted on req_valid && req_ready; cmd consumed on cmd_valid && cmd_ready.
  // While cmd_valid is high and cmd_ready low, all cmd_* fields hold and no tracker update fires.
  state_t              state, state_nxt;
  logic                lat_is_write;
  logic [BG_W-1:0]     lat_bg;
  logic [BANK_W-1:0]   lat_bank;
  logic [ROW_W-1:0]    lat_row;
  logic [COL_W-1:0]    lat_col;
  logic                cmd_hs;
  logic                row_hit;
  logic                timer_load;
  logic                timer_done;
  logic [CNT_W-1:0]    timer_val;

  assign trk_clear            = sched_clear;
  assign trk_query_bank_group = lat_bg;
  assign trk_query_bank       = lat_bank;
  assign cmd_bank_group       = lat_bg;
  assign cmd_bank             = lat_bank;
  assign cmd_row              = lat_row;
  assign cmd_col              = lat_col;
  assign trk_upd_bank_group   = lat_bg;
  assign trk_upd_bank         = lat_bank;
  assign trk_upd_row          = lat_row;
  assign row_hit              = trk_is_row_open && (trk_open_row == lat_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (req_valid) state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (row_hit)              state_nxt = ST_CAS;
        else if (trk_is_row_open) state_nxt = ST_PRE;
        else                      state_nxt = ST_ACT;
      end
      ST_PRE:      if (cmd_ready)  state_nxt = ST_WAIT_RP;
      ST_WAIT_RP:  if (timer_done) state_nxt = ST_ACT;
      ST_ACT:      if (cmd_ready)  state_nxt = ST_WAIT_RCD;
      ST_WAIT_RCD: if (timer_done) state_nxt = ST_CAS;
      ST_CAS:      if (cmd_ready)  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (sched_clear) state_nxt = ST_IDLE;
  end

  always_comb begin
    req_ready         = (state == ST_IDLE) && !sched_clear;
    cmd_valid         = 1'b0;
    cmd_type          = CMD_NOP;
    case (state)
      ST_PRE: begin cmd_valid = 1'b1; cmd_type = CMD_PRE; end
      ST_ACT: begin cmd_valid = 1'b1; cmd_type = CMD_ACT; end
      ST_CAS: begin cmd_valid = 1'b1; cmd_type = lat_is_write ? CMD_WR : CMD_RD; end
      default: ;
    endcase
    cmd_hs            = cmd_valid && cmd_ready;
    trk_upd_precharge = cmd_hs && (state == ST_PRE) && !sched_clear;
    trk_upd_activate  = cmd_hs && (state == ST_ACT) && !sched_clear;
    timer_load        = cmd_hs && ((state == ST_PRE) || (state == ST_ACT));
    timer_val         = (state == ST_PRE) ? CNT_W'(T_RP - 2) : CNT_W'(T_RCD - 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_is_write <= 1'b0;
      lat_bg       <= '0;
      lat_bank     <= '0;
      lat_row      <= '0;
      lat_col      <= '0;
    end else if (req_valid && req_ready) begin
      lat_is_write <= req_is_write;
      lat_bg       <= req_bank_group;
      lat_bank     <= req_bank;
      lat_row      <= req_row;
      lat_col      <= req_col;
    end
  end

  // A lookup that coincides with sched_clear is dropped and not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits      <= '0;
      stat_misses    <= '0;
      stat_conflicts <= '0;
    end else if ((state == ST_LOOKUP) && !sched_clear) begin
      if (row_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else if (trk_is_row_open) begin
        if (stat_conflicts != '1) stat_conflicts <= stat_conflicts + 1'b1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
    end
  end

  cmd_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

endmodule

// File: tb/tb_row_cmd_emitter.sv
// Directed bench for row_cmd_emitter: a bank tracker model, a request driver and a command
// scoreboard that checks type, fields, issue cycle and tracker update pulses.
module tb_row_cmd_emitter;
  import row_cmd_emitter_pkg::*;

  localparam int T_RP   = 3;
  localparam int T_RCD  = 4;
  localparam int STAT_W = 4;
  localparam int W      = 49; // {cycle[16], type[3], bg[2], bank[2], row[16], col[10]}

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sched_clear;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_write;
  logic [BG_W-1:0]   req_bank_group;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_type;
  logic [BG_W-1:0]   cmd_bank_group;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic              trk_clear;
  logic [BG_W-1:0]   trk_query_bank_group;
  logic [BANK_W-1:0] trk_query_bank;
  logic              trk_is_row_open;
  logic [ROW_W-1:0]  trk_open_row;
  logic              trk_upd_activate;
  logic              trk_upd_precharge;
  logic [BG_W-1:0]   trk_upd_bank_group;
  logic [BANK_W-1:0] trk_upd_bank;
  logic [ROW_W-1:0]  trk_upd_row;
  logic [STAT_W-1:0] stat_hits;
  logic [STAT_W-1:0] stat_misses;
  logic [STAT_W-1:0] stat_conflicts;

  row_cmd_emitter #(.T_RP(T_RP), .T_RCD(T_RCD), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sched_clear(sched_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_bank_group(req_bank_group), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bank_group(cmd_bank_group), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .trk_clear(trk_clear), .trk_query_bank_group(trk_query_bank_group),
    .trk_query_bank(trk_query_bank), .trk_is_row_open(trk_is_row_open),
    .trk_open_row(trk_open_row), .trk_upd_activate(trk_upd_activate),
    .trk_upd_precharge(trk_upd_precharge), .trk_upd_bank_group(trk_upd_bank_group),
    .trk_upd_bank(trk_upd_bank), .trk_upd_row(trk_upd_row),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_conflicts(stat_conflicts)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bank tracker model ----------------
  logic             trk_open [16];
  logic [ROW_W-1:0] trk_rows [16];
  logic             tb_set_en = 1'b0;
  logic [3:0]       tb_set_idx = '0;
  logic             tb_set_open = 1'b0;
  logic [ROW_W-1:0] tb_set_row = '0;

  always @(posedge clk) begin
    if (!rst_n || trk_clear) begin
      for (int i = 0; i < 16; i++) trk_open[i] <= 1'b0;
    end else begin
      if (trk_upd_precharge) trk_open[{trk_upd_bank_group, trk_upd_bank}] <= 1'b0;
      if (trk_upd_activate) begin
        trk_open[{trk_upd_bank_group, trk_upd_bank}] <= 1'b1;
        trk_rows[{trk_upd_bank_group, trk_upd_bank}] <= trk_upd_row;
      end
      if (tb_set_en) begin
        trk_open[tb_set_idx] <= tb_set_open;
        trk_rows[tb_set_idx] <= tb_set_row;
      end
    end
  end

  assign trk_is_row_open = trk_open[{trk_query_bank_group, trk_query_bank}];
  assign trk_open_row    = trk_rows[{trk_query_bank_group, trk_query_bank}];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input int c, input logic [2:0] ty, input logic [1:0] bg,
                          input logic [1:0] bk, input logic [15:0] row, input logic [9:0] col);
    exp_q.push_back({16'(c), ty, bg, bk, row, col});
  endtask

  logic [W-1:0] e;
  logic [2:0]   e_ty;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_cmd: got type %0d at cycle %0d, required none", cmd_type, cyc);
        end else begin
          e    = exp_q[0];
          e_ty = e[32:30];
          check("cmd_type", 32'(cmd_type), 32'(e_ty));
          check("cmd_bank_group", 32'(cmd_bank_group), 32'(e[29:28]));
          check("cmd_bank", 32'(cmd_bank), 32'(e[27:26]));
          if (e_ty == CMD_ACT) check("cmd_row", 32'(cmd_row), 32'(e[25:10]));
          if (e_ty == CMD_RD || e_ty == CMD_WR) check("cmd_col", 32'(cmd_col), 32'(e[9:0]));
          if (cmd_ready) begin
            check("cmd_cycle", 32'(cyc), 32'(e[48:33]));
            check("upd_activate", 32'(trk_upd_activate), 32'((e_ty == CMD_ACT) && !sched_clear));
            check("upd_precharge", 32'(trk_upd_precharge), 32'((e_ty == CMD_PRE) && !sched_clear));
            if (e_ty == CMD_ACT) begin
              check("upd_row", 32'(trk_upd_row), 32'(e[25:10]));
              check("upd_bank", 32'({trk_upd_bank_group, trk_upd_bank}), 32'(e[29:26]));
            end
            exp_q.delete(0);
          end else begin
            check("stall_upd", 32'({trk_upd_activate, trk_upd_precharge}), 32'(0));
          end
        end
      end else begin
        check("idle_type", 32'(cmd_type), 32'(CMD_NOP));
        check("idle_upd", 32'({trk_upd_activate, trk_upd_precharge}), 32'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [1:0] bg, input logic [1:0] bk, input logic open,
                          input logic [15:0] row);
    tb_set_en = 1'b1; tb_set_idx = {bg, bk}; tb_set_open = open; tb_set_row = row;
    next_cycle();
    tb_set_en = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      next_cycle();
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending commands, required 0", exp_q.size());
      exp_q.delete();
    end
    next_cycle();
  endtask

  // kind: 0 hit, 1 miss, 2 conflict; stall = cycles cmd_ready held low once the first command shows
  task automatic do_req(input logic wr, input logic [1:0] bg, input logic [1:0] bk,
                        input logic [15:0] row, input logic [9:0] col, input int kind,
                        input int stall);
    int t0;
    int guard = 0;
    logic [2:0] cas;
    while (!req_ready && guard < 100) begin
      next_cycle();
      guard++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_timeout: got 0 required 1");
    end
    cas = wr ? CMD_WR : CMD_RD;
    if (stall > 0) cmd_ready = 1'b0;
    req_valid = 1'b1; req_is_write = wr; req_bank_group = bg; req_bank = bk;
    req_row = row; req_col = col;
    t0 = cyc;
    case (kind)
      0: push_cmd(t0 + 2 + stall, cas, bg, bk, row, col);
      1: begin
        push_cmd(t0 + 2 + stall, CMD_ACT, bg, bk, row, col);
        push_cmd(t0 + 2 + stall + T_RCD, cas, bg, bk, row, col);
      end
      default: begin
        push_cmd(t0 + 2 + stall, CMD_PRE, bg, bk, row, col);
        push_cmd(t0 + 2 + stall + T_RP, CMD_ACT, bg, bk, row, col);
        push_cmd(t0 + 2 + stall + T_RP + T_RCD, cas, bg, bk, row, col);
      end
    endcase
    next_cycle();
    req_valid = 1'b0;
    if (stall > 0) begin
      while (cyc < t0 + 2 + stall) next_cycle();
      cmd_ready = 1'b1;
    end
    wait_drain();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0;
    rst_n = 1'b0; sched_clear = 1'b0; req_valid = 1'b0; req_is_write = 1'b0;
    req_bank_group = '0; req_bank = '0; req_row = '0; req_col = '0; cmd_ready = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    check("rst_cmd_type", 32'(cmd_type), 32'(CMD_NOP));
    check("rst_upd", 32'({trk_upd_activate, trk_upd_precharge}), 32'(0));
    check("rst_latch", 32'({cmd_bank_group, cmd_bank, cmd_row}), 32'(0));
    check("rst_stats", 32'({stat_hits, stat_misses, stat_conflicts}), 32'(0));
    rst_n = 1'b1;
    next_cycle();

    // hit: bank (1,2) open row 0x0040
    set_bank(2'd1, 2'd2, 1'b1, 16'h0040);
    do_req(1'b0, 2'd1, 2'd2, 16'h0040, 10'h010, 0, 0);
    check("hit_stat", 32'(stat_hits), 32'(1));

    // miss: all precharged
    do_req(1'b1, 2'd0, 2'd0, 16'h1234, 10'h003, 1, 0);
    check("miss_stat", 32'(stat_misses), 32'(1));

    // conflict: bank (3,1) open row 0x0005, request row 0x0009
    set_bank(2'd3, 2'd1, 1'b1, 16'h0005);
    do_req(1'b0, 2'd3, 2'd1, 16'h0009, 10'h022, 2, 0);
    check("conflict_stat", 32'(stat_conflicts), 32'(1));

    // backpressure: miss with ACT held for 5 cycles
    do_req(1'b0, 2'd2, 2'd0, 16'h0777, 10'h055, 1, 5);
    check("bp_miss_stat", 32'(stat_misses), 32'(2));

    // clear during WAIT_RP: (3,1) now holds row 0x0009, so 0xAAAA conflicts
    while (!req_ready) next_cycle();
    req_valid = 1'b1; req_is_write = 1'b0; req_bank_group = 2'd3; req_bank = 2'd1;
    req_row = 16'hAAAA; req_col = 10'h001;
    t0 = cyc;
    push_cmd(t0 + 2, CMD_PRE, 2'd3, 2'd1, 16'hAAAA, 10'h001);
    next_cycle();
    req_valid = 1'b0;
    while (cyc < t0 + 3) next_cycle();
    sched_clear = 1'b1;
    #1;
    check("clear_trk_clear", 32'(trk_clear), 32'(1));
    check("clear_req_ready_forced", 32'(req_ready), 32'(0));
    next_cycle();
    sched_clear = 1'b0;
    #1;
    check("clear_idle_ready", 32'(req_ready), 32'(1));
    check("clear_cmd_valid", 32'(cmd_valid), 32'(0));
    repeat (12) next_cycle();
    check("clear_pending", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    check("clear_stat_conf", 32'(stat_conflicts), 32'(2));
    check("clear_stat_miss", 32'(stat_misses), 32'(2));
    check("clear_stat_hit", 32'(stat_hits), 32'(1));

    // request coinciding with sched_clear in IDLE must be refused
    req_valid = 1'b1; sched_clear = 1'b1; req_bank_group = 2'd1; req_bank = 2'd2;
    req_row = 16'h0040; req_col = 10'h011;
    #1;
    check("clear_refuse_ready", 32'(req_ready), 32'(0));
    next_cycle();
    req_valid = 1'b0; sched_clear = 1'b0;
    #1;
    check("clear_refuse_idle", 32'(req_ready), 32'(1));
    repeat (6) next_cycle();

    // recovery: tracker was cleared, so (1,2) is now a miss
    do_req(1'b0, 2'd1, 2'd2, 16'h0040, 10'h011, 1, 0);
    check("recover_miss_stat", 32'(stat_misses), 32'(3));

    // saturation: 18 more hits on a 4-bit counter already at 1
    for (int i = 0; i < 18; i++) do_req(1'b0, 2'd1, 2'd2, 16'h0040, 10'(i), 0, 0);
    check("sat_hits", 32'(stat_hits), 32'(15));
    check("sat_misses_kept", 32'(stat_misses), 32'(3));

    // reset mid-operation: miss request, reset while ACT waits on a stalled bus
    cmd_ready = 1'b0;
    while (!req_ready) next_cycle();
    req_valid = 1'b1; req_is_write = 1'b1; req_bank_group = 2'd0; req_bank = 2'd3;
    req_row = 16'h0101; req_col = 10'h007;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_valid", 32'(cmd_valid), 32'(0));
    check("midrst_req_ready", 32'(req_ready), 32'(1));
    check("midrst_stats", 32'({stat_hits, stat_misses, stat_conflicts}), 32'(0));
    check("midrst_upd", 32'({trk_upd_activate, trk_upd_precharge}), 32'(0));
    next_cycle();
    cmd_ready = 1'b1;
    rst_n = 1'b1;
    repeat (4) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/row_cmd_emitter.md
Name: row_cmd_emitter

Overview:
- Schedule-emission stage: accepts one access request at a time, queries the bank state tracker, and emits the required PRE/ACT/RD/WR sequence on a valid/ready command stream.
- Sits directly upstream of the bank state tracker. It drives the tracker query port and issues tracker updates exactly when PRE/ACT commands are accepted.
- Enforces tRP and tRCD gaps with an internal wait counter and keeps row hit/miss/conflict statistics.

Parameters:
- T_RP, 3, cycles from accepted PRE to first ACT cmd_valid (must be >=2).
- T_RCD, 4, cycles from accepted ACT to first RD/WR cmd_valid (must be >=2).
- STAT_W, 16, width of each statistics counter.
- BANK_GROUP_WIDTH, BANK_WIDTH, ROW_WIDTH and COL_WIDTH come from dram_scheduler_types.vh (defaults 2, 2, 16, 10).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sched_clear  in  1  abort the in-flight request and clear the tracker
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_is_write  in  1  1 = WR, 0 = RD
- req_bank_group  in  BANK_GROUP_WIDTH  target bank group
- req_bank  in  BANK_WIDTH  target bank
- req_row  in  ROW_WIDTH  target row
- req_col  in  COL_WIDTH  target column
- cmd_valid  out  1  command valid
- cmd_ready  in  1  command consumed when valid&&ready
- cmd_type  out  3  0 NOP, 1 PRE, 2 ACT, 3 RD, 4 WR
- cmd_bank_group  out  BANK_GROUP_WIDTH  command bank group
- cmd_bank  out  BANK_WIDTH  command bank
- cmd_row  out  ROW_WIDTH  command row (ACT; otherwise the latched row)
- cmd_col  out  COL_WIDTH  command column (RD/WR; otherwise the latched column)
- trk_clear  out  1  to tracker clear
- trk_query_bank_group  out  BANK_GROUP_WIDTH  tracker query
- trk_query_bank  out  BANK_WIDTH  tracker query
- trk_is_row_open  in  1  tracker response
- trk_open_row  in  ROW_WIDTH  tracker response
- trk_upd_activate  out  1  tracker update on ACT
- trk_upd_precharge  out  1  tracker update on PRE
- trk_upd_bank_group  out  BANK_GROUP_WIDTH  update bank group
- trk_upd_bank  out  BANK_WIDTH  update bank
- trk_upd_row  out  ROW_WIDTH  update row
- stat_hits  out  STAT_W  row-hit count
- stat_misses  out  STAT_W  bank-precharged count
- stat_conflicts  out  STAT_W  wrong-row-open count

Behaviour:
- Reset values: state IDLE; all request latches 0; wait counter 0; stats 0. Outputs: req_ready=1, cmd_valid=0, cmd_type=NOP, trk_upd_* = 0.
- States: IDLE, LOOKUP, PRE, WAIT_RP, ACT, WAIT_RCD, CAS.
- IDLE: req_ready=1. On req_valid, latch bank_group, bank, row, col and is_write, then go to LOOKUP. req_ready=0 in every other state.
- Tracker query ports are driven from the latched request in every state; the tracker answers combinationally.
- LOOKUP (one cycle), decided from the tracker response:
  - row open and trk_open_row == latched row: hit. stat_hits+1, go to CAS.
  - row open, different row: conflict. stat_conflicts+1, go to PRE.
  - row not open: miss. stat_misses+1, go to ACT.
- PRE: cmd_valid=1, cmd_type=PRE. On handshake, assert trk_upd_precharge for that cycle only and go to WAIT_RP.
- ACT: cmd_valid=1, cmd_type=ACT, cmd_row = latched row. On handshake, assert trk_upd_activate with trk_upd_row = latched row and go to WAIT_RCD.
- CAS: cmd_valid=1, cmd_type = WR if is_write else RD. On handshake, go to IDLE; req_ready=1 in the next cycle.
- Timing gaps: if PRE is accepted at cycle t, ACT cmd_valid first asserts at t+T_RP. If ACT is accepted at cycle t, RD/WR cmd_valid first asserts at t+T_RCD. The wait counter is down-counting and loaded on the accepting handshake.
- Stall: while cmd_valid=1 and cmd_ready=0, cmd_* hold stable and there is no tracker update.
- cmd_valid is 0 and cmd_type is NOP in IDLE, LOOKUP, WAIT_RP and WAIT_RCD.
- cmd_bank_group/cmd_bank always equal the latched request fields.
- Stats saturate at all-ones and are never cleared except by reset.
- Minimum latencies, request accept at cycle 0:
  - hit: RD/WR valid at cycle 2.
  - miss: ACT valid at 2.
  - conflict: PRE valid at 2.
- sched_clear:
  - trk_clear = sched_clear, combinational.
  - FSM returns to IDLE next cycle regardless of state; the request is dropped.
  - trk_upd_* are forced 0 in any cycle where sched_clear=1, even if a handshake occurs. That command is still considered emitted; downstream must tolerate this.
  - req_valid in the same cycle as sched_clear is not accepted (req_ready forced 0).
- Reset mid-operation: immediate return to reset values; no command completes.

Decomposition:
- dram_scheduler_types.vh holds the width macros plus new command encodings CMD_NOP, CMD_PRE, CMD_ACT, CMD_RD and CMD_WR.
- One sub-module: cmd_wait_timer (load value, load strobe, done flag), shared by WAIT_RP and WAIT_RCD.
- The FSM, request latch and stats stay in row_cmd_emitter.

Test Plan:
- Hit: tracker bank (1,2) open row 0x0040; request RD (1,2,row 0x0040, col 0x10), cmd_ready=1 -> single RD at cycle 2, col 0x10, no trk_upd, stat_hits=1.
- Miss: all banks precharged; WR (0,0,row 0x1234) -> ACT at cycle 2 with row 0x1234 and trk_upd_activate pulse; WR at cycle 2+T_RCD=6; stat_misses=1.
- Conflict: bank (3,1) open row 0x0005; RD to row 0x0009 -> PRE at cycle 2, ACT at 5 (T_RP=3), RD at 9; trk_upd_precharge then trk_upd_activate row 0x0009; stat_conflicts=1.
- Backpressure: miss request with cmd_ready=0 for 5 cycles during ACT -> ACT fields stable, no trk_upd until the ready cycle; the RD gap is counted from the actual handshake.
- Clear: sched_clear asserted during WAIT_RP -> trk_clear=1 that cycle, IDLE next cycle with req_ready=1, no further commands, stats unchanged.
- Saturation: force 2^STAT_W+2 hits (STAT_W=4 build) -> stat_hits holds 0xF.
